// File: rtl/reed_solomon_decoder_symbol_unpacker_if.sv
// Bundle between the 512-bit show-ahead input FIFO, the symbol unpacker and
// the syndrome stage. The master modport is the unpacker side; the slave
// modport is the FIFO / downstream side.
interface reed_solomon_decoder_symbol_unpacker_if;
  logic [511:0] fifo_deq_data;
  logic         fifo_not_empty;
  logic         fifo_deq_en;
  logic [7:0]   sym_data;
  logic         sym_valid;
  logic         sym_ready;
  logic         sym_sop;
  logic         sym_eop;

  modport master (
    input  fifo_deq_data, fifo_not_empty, sym_ready,
    output fifo_deq_en, sym_data, sym_valid, sym_sop, sym_eop
  );

  modport slave (
    output fifo_deq_data, fifo_not_empty, sym_ready,
    input  fifo_deq_en, sym_data, sym_valid, sym_sop, sym_eop
  );
endinterface

// File: rtl/reed_solomon_decoder_symbol_unpacker.sv
// Reed-Solomon symbol unpacker: pops 512-bit FIFO words, emits them byte 0
// first as 8-bit symbols, and marks codeword boundaries every CW_LEN symbols
// independently of word alignment. One symbol per cycle, no bubble between
// words (the next word is popped on the accept of byte 63).
// Optional feature macro: REED_SOLOMON_DECODER_UNPACK_STATS_EN enables the
// popped-word counter; otherwise word_count is tied to 0.
module reed_solomon_decoder_symbol_unpacker #(
  parameter int CW_LEN = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  reed_solomon_decoder_symbol_unpacker_if.master bus,
  output logic [15:0] cw_count,
  output logic [31:0] word_count
);

  localparam logic [0:0]  S_EMPTY  = 1'b0;
  localparam logic [0:0]  S_HOLD   = 1'b1;
  localparam logic [15:0] SYM_LAST = 16'(CW_LEN - 1);

  logic [0:0]   state_q, state_d;
  logic [511:0] hold_q, hold_d;
  logic [5:0]   byte_idx_q, byte_idx_d;
  logic [15:0]  sym_idx_q, sym_idx_d;
  logic [15:0]  cw_q, cw_d;

  logic accept;
  logic last_byte;
  logic last_sym;
  logic deq_en;

  // Handshake decode; pops are suppressed during reset and flush.
  always_comb begin
    accept    = (state_q == S_HOLD) && bus.sym_ready;
    last_byte = (byte_idx_q == 6'd63);
    last_sym  = (sym_idx_q == SYM_LAST);
    deq_en    = reset_n && !flush && bus.fifo_not_empty &&
                ((state_q == S_EMPTY) || (accept && last_byte));
  end

  assign bus.fifo_deq_en = deq_en;
  assign bus.sym_valid   = (state_q == S_HOLD);
  assign bus.sym_data    = hold_q[{byte_idx_q, 3'b000} +: 8];
  assign bus.sym_sop     = (state_q == S_HOLD) && (sym_idx_q == 16'd0);
  assign bus.sym_eop     = (state_q == S_HOLD) && last_sym;
  assign cw_count        = cw_q;

  // Next-state: flush wins over everything, including a same-cycle accept.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    byte_idx_d = byte_idx_q;
    sym_idx_d  = sym_idx_q;
    cw_d       = cw_q;
    if (flush) begin
      state_d    = S_EMPTY;
      byte_idx_d = 6'd0;
      sym_idx_d  = 16'd0;
    end else begin
      if (deq_en) begin
        hold_d     = bus.fifo_deq_data;
        byte_idx_d = 6'd0;
        state_d    = S_HOLD;
      end else if (accept) begin
        if (last_byte) state_d    = S_EMPTY;
        else           byte_idx_d = byte_idx_q + 6'd1;
      end
      if (accept) begin
        if (last_sym) begin
          sym_idx_d = 16'd0;
          cw_d      = cw_q + 16'd1;
        end else begin
          sym_idx_d = sym_idx_q + 16'd1;
        end
      end
    end
  end

  // State registers; reset drops any partial word or codeword.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_EMPTY;
      hold_q     <= '0;
      byte_idx_q <= '0;
      sym_idx_q  <= '0;
      cw_q       <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      byte_idx_q <= byte_idx_d;
      sym_idx_q  <= sym_idx_d;
      cw_q       <= cw_d;
    end
  end

`ifdef REED_SOLOMON_DECODER_UNPACK_STATS_EN
  logic [31:0] wc_q;

  // Popped-word counter; flush cannot pop so it never disturbs this count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    wc_q <= '0;
    else if (deq_en) wc_q <= wc_q + 32'd1;
  end

  assign word_count = wc_q;
`else
  assign word_count = 32'd0;
`endif

endmodule

// File: doc/reed_solomon_decoder_symbol_unpacker.md
# reed_solomon_decoder_symbol_unpacker

Downstream consumer of the decoder's 512-bit input FIFO. Pops 512-bit words over the FIFO's show-ahead dequeue interface, serialises each word into 64 8-bit Reed-Solomon symbols, and frames them into codewords of `CW_LEN` symbols. Output is a valid/ready symbol stream with start/end-of-codeword markers, feeding the syndrome stage. Sustains one symbol per cycle with no bubble between consecutive FIFO words.

## Interface
- `CW_LEN`, 255: symbols per codeword; legal range 2..65535.
- `clk` input 1: clock; all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `fifo_deq_data` input 512: FIFO head word, show-ahead (valid whenever `fifo_not_empty`=1).
- `fifo_not_empty` input 1: FIFO holds at least one word.
- `fifo_deq_en` output 1: pop strobe; head word is captured in the same cycle.
- `flush` input 1: synchronous abort of current word and codeword framing.
- `sym_data` output 8: current symbol.
- `sym_valid` output 1: `sym_data`/`sym_sop`/`sym_eop` valid.
- `sym_ready` input 1: downstream accepts symbol.
- `sym_sop` output 1: symbol is index 0 of a codeword.
- `sym_eop` output 1: symbol is index `CW_LEN`-1 of a codeword.
- `cw_count` output 16: codewords completed (EOP accepted), wraps 65535→0.
- `word_count` output 32: FIFO words popped (see Configuration).

## Operation
- Registers: 512-bit holding register, 6-bit byte index, 16-bit symbol index, state.
- States: EMPTY (no word held), HOLD (word held, presenting byte index).
- Byte order: byte k = holding[8k+7:8k]; byte 0 is emitted first.
- `sym_data` = holding byte at byte index; `sym_valid` = (state==HOLD).
- `sym_sop` = valid && symbol index==0; `sym_eop` = valid && symbol index==`CW_LEN`-1.
- EMPTY: if `fifo_not_empty` && !`flush`: `fifo_deq_en`=1, capture `fifo_deq_data`, byte index←0, →HOLD.
- HOLD, accept (`sym_valid`&&`sym_ready`):
  - Byte index <63: byte index+1.
  - Byte index ==63 and `fifo_not_empty`: `fifo_deq_en`=1, reload, byte index←0, stay HOLD.
  - Byte index ==63 and FIFO empty: →EMPTY.
  - Symbol index: wraps to 0 at `CW_LEN`-1, else +1. On EOP accept, `cw_count`+1.
- HOLD with no accept: all state frozen; `sym_data`/`sym_sop`/`sym_eop` stable while `sym_valid`=1 and `sym_ready`=0.
- `fifo_deq_en` is combinational and is never asserted when `fifo_not_empty`=0 or `flush`=1.
- Codewords span word boundaries freely; framing is independent of word alignment.
- `flush` (highest priority): →EMPTY, byte index←0, symbol index←0, no pop, no count update, including a same-cycle accept. Holding register contents are don't-care.

## Timing
- Reset values: state EMPTY; `sym_valid`, `sym_sop`, `sym_eop`, `fifo_deq_en` = 0; `sym_data` = 0 (holding cleared); `cw_count`, `word_count` = 0.
- Latency: word popped in cycle T; its byte 0 is valid in cycle T+1.
- Throughput: with `sym_ready`=1 and FIFO non-empty, 64 symbols per 64 cycles, no gap between words.
- `reset_n` assertion mid-word or mid-codeword: partial data is dropped immediately; FIFO is not popped during reset.

## Configuration
- `REED_SOLOMON_DECODER_UNPACK_STATS_EN` defined: `word_count` increments on each `fifo_deq_en` cycle, wraps at 2^32, and is unaffected by `flush`.
- Not defined: counter logic is omitted and `word_count` is tied to 0. The port is always present.

## Test plan
- Reset, FIFO empty for 10 cycles: `fifo_deq_en`=0, `sym_valid`=0 throughout, all counts 0.
- One word 0x3F3E…0100 (byte k = k), `sym_ready`=1: symbols 0x00..0x3F on 64 consecutive cycles starting T+1; `sym_sop` on 0x00 only; state EMPTY afterwards.
- Five words back-to-back, `sym_ready`=1: 320 symbols with no bubble and `fifo_deq_en` pulses exactly 64 cycles apart. EOP on symbol 254 (word 3, byte 62); SOP on symbol 255 (word 3, byte 63); `cw_count`=1. With STATS_EN, `word_count`=5.
- `sym_ready` toggled pseudo-randomly over 2 words: symbol sequence is identical to the `sym_ready`=1 case, and outputs are held while stalled.
- `flush` at byte 20 of word 0: next word restarts at byte 0 with `sym_sop`=1; `cw_count` unchanged; no pop in the flush cycle.
- `reset_n` low at symbol 100 then released: outputs return to reset values, and the next popped word's byte 0 carries `sym_sop`=1.
